alu_mul_ctrl: RTL and testbench

ALU_MUL_CTRL -- requirements
Module: alu_mul_ctrl

---
 rtl/alu_mul_ctrl_if.sv | 26 ++
 rtl/alu_mul_ctrl.sv | 136 +++++++++++++
 tb/tb_alu_mul_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_ctrl_if.sv
// Bundles the request/result handshake and the shared ALU port of the shift-and-add multiplier controller.
// The master side issues requests and hosts the ALU; the slave side is the controller.
interface alu_mul_ctrl_if;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        ovf;
  logic [3:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_out;
  logic [3:0]  alu_flags;

  modport slave (
    input  start, op_a, op_b, alu_out, alu_flags,
    output busy, done, product, ovf, alu_op, alu_a, alu_b
  );

  modport master (
    output start, op_a, op_b, alu_out, alu_flags,
    input  busy, done, product, ovf, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/alu_mul_ctrl.sv
// Unsigned 16x16 shift-and-add multiplier sequenced over an external ALU; done after popcount(b)+bitlen(b)+1 cycles.
// No backpressure: start is sampled only in IDLE, and starts arriving while busy are dropped.
module alu_mul_ctrl (
  input  logic            clk,
  input  logic            rst,
  alu_mul_ctrl_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_SHL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd7;

  logic [1:0]  state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic        ovf_r_q, ovf_r_d;
  logic [15:0] product_q, product_d;
  logic        ovf_q, ovf_d;

  logic [3:0]  alu_op_c;
  logic [15:0] alu_a_c;
  logic [15:0] alu_b_c;
  logic        alu_carry;

  assign alu_carry = bus.alu_flags[1];

  // ALU drive depends only on state and registers, never on start.
  always_comb begin
    alu_op_c = OP_PASS;
    alu_a_c  = 16'd0;
    alu_b_c  = 16'd0;
    case (state_q)
      S_ADD: begin
        alu_op_c = OP_ADD;
        alu_a_c  = acc_q;
        alu_b_c  = mcand_q;
      end
      S_SHL: begin
        alu_op_c = OP_SHL;
        alu_a_c  = mcand_q;
      end
      default: begin
        alu_op_c = OP_PASS;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    ovf_r_d   = ovf_r_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d    = 16'd0;
          mcand_d  = bus.op_a;
          mplier_d = bus.op_b;
          ovf_r_d  = 1'b0;
          if (bus.op_b == 16'd0) begin
            state_d = S_DONE;
          end else if (bus.op_b[0]) begin
            state_d = S_ADD;
          end else begin
            state_d = S_SHL;
          end
        end
      end
      S_ADD: begin
        acc_d = bus.alu_out;
        if (alu_carry) begin
          ovf_r_d = 1'b1;
        end
        state_d = S_SHL;
      end
      S_SHL: begin
        mcand_d  = bus.alu_out;
        mplier_d = mplier_q >> 1;
        // A bit shifted out of mcand only matters if more multiplier bits remain.
        if (alu_carry && (mplier_d != 16'd0)) begin
          ovf_r_d = 1'b1;
        end
        if (mplier_d == 16'd0) begin
          state_d = S_DONE;
        end else if (mplier_q[1]) begin
          state_d = S_ADD;
        end else begin
          state_d = S_SHL;
        end
      end
      default: begin
        product_d = acc_q;
        ovf_d     = ovf_r_q;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= 16'd0;
      mcand_q   <= 16'd0;
      mplier_q  <= 16'd0;
      ovf_r_q   <= 1'b0;
      product_q <= 16'd0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      ovf_r_q   <= ovf_r_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.product = product_q;
  assign bus.ovf     = ovf_q;
  assign bus.alu_op  = alu_op_c;
  assign bus.alu_a   = alu_a_c;
  assign bus.alu_b   = alu_b_c;

endmodule

// File: tb/tb_alu_mul_ctrl.sv
// Scoreboard bench for alu_mul_ctrl: directed operand pairs with hand-computed product, overflow and latency,
// plus a behavioural 16-bit ALU on the alu_* port.
module tb_alu_mul_ctrl;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  alu_mul_ctrl_if bus();

  alu_mul_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: ADD=5, SHL=7, PASS=0; flag bit1 = carry, bit0 = zero.
  logic [16:0] alu_res;
  always_comb begin
    alu_res = 17'd0;
    case (bus.alu_op)
      4'd5:    alu_res = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      4'd7:    alu_res = {bus.alu_a, 1'b0};
      4'd0:    alu_res = {1'b0, bus.alu_a};
      default: alu_res = 17'd0;
    endcase
  end
  assign bus.alu_out   = alu_res[15:0];
  assign bus.alu_flags = {2'b00, alu_res[16], (alu_res[15:0] == 16'd0)};

  typedef struct {
    logic [15:0] prod;
    logic        ovf;
    int          lat;
    logic [63:0] sig;
    int          nops;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected ALU op trace: per multiplier bit up to the top set bit, ADD if set, then SHL.
  task automatic push_exp(input logic [15:0] b, input logic [15:0] prod, input logic ovf, input int lat);
    exp_t e;
    logic [15:0] m;
    e.prod = prod;
    e.ovf  = ovf;
    e.lat  = lat;
    e.sig  = 64'd0;
    e.nops = 0;
    m = b;
    while (m != 16'd0) begin
      if (m[0]) begin
        e.sig = {e.sig[61:0], 2'b01};
        e.nops++;
      end
      e.sig = {e.sig[61:0], 2'b10};
      e.nops++;
      m = m >> 1;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: tracks accepted starts, records the ALU op trace, checks results after each done.
  bit          inflight;
  bit          chk_pending;
  int          c0;
  int          lat_m;
  int          nops_m;
  logic [63:0] sig_m;
  logic [15:0] prev_prod;
  logic        prev_ovf;

  initial begin
    exp_t cur;
    inflight    = 1'b0;
    chk_pending = 1'b0;
    c0 = 0; lat_m = 0; nops_m = 0; sig_m = 64'd0;
    prev_prod = 16'd0; prev_ovf = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        inflight    = 1'b0;
        chk_pending = 1'b0;
        prev_prod   = bus.product;
        prev_ovf    = bus.ovf;
      end else begin
        if (chk_pending) begin
          chk_pending = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got product %0h, expected no transaction", bus.product);
          end else begin
            cur = exp_q.pop_front();
            check("product", 64'(bus.product), 64'(cur.prod));
            check("ovf", 64'(bus.ovf), 64'(cur.ovf));
            check("latency", 64'(lat_m), 64'(cur.lat));
            check("alu_op_seq", sig_m, cur.sig);
            check("alu_op_count", 64'(nops_m), 64'(cur.nops));
          end
        end else begin
          check("result_stable", 64'({bus.product, bus.ovf}), 64'({prev_prod, prev_ovf}));
        end
        prev_prod = bus.product;
        prev_ovf  = bus.ovf;
        if (!bus.busy) begin
          check("idle_alu_pass", 64'({bus.alu_op, bus.alu_a, bus.alu_b}), 64'd0);
        end
        if (inflight && (bus.alu_op != 4'd0)) begin
          sig_m = {sig_m[61:0], (bus.alu_op == 4'd5) ? 2'b01 : (bus.alu_op == 4'd7) ? 2'b10 : 2'b11};
          nops_m++;
        end
        if (bus.done) begin
          if (inflight) begin
            lat_m       = cyc - c0;
            chk_pending = 1'b1;
            inflight    = 1'b0;
          end else begin
            checks++;
            errors++;
            $display("FAIL stray_done: got done=1, expected 0 (cycle %0d)", cyc);
          end
        end
        if (!bus.busy && bus.start) begin
          inflight = 1'b1;
          c0       = cyc;
          sig_m    = 64'd0;
          nops_m   = 0;
        end
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] prod, input logic ovf, input int lat);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    push_exp(b, prod, ovf, lat);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: got busy=%0d pending=%0d, expected idle", bus.busy, exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL wait_done_timeout: got done=0, expected done within 100 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op_a  = 16'd0;
    bus.op_b  = 16'd0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", 64'({bus.busy, bus.done, bus.product, bus.ovf, bus.alu_op, bus.alu_a, bus.alu_b}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Start on the first edge after reset release.
    issue(16'd3,     16'd5,     16'd15,    1'b0, 6);  wait_idle();
    issue(16'h1234,  16'd0,     16'd0,     1'b0, 1);  wait_idle();
    issue(16'hFFFF,  16'd1,     16'hFFFF,  1'b0, 3);  wait_idle();
    issue(16'h0100,  16'h0100,  16'd0,     1'b1, 11); wait_idle();
    issue(16'hFFFF,  16'hFFFF,  16'h0001,  1'b1, 33); wait_idle();
    issue(16'h00FF,  16'h0101,  16'hFFFF,  1'b0, 12); wait_idle();
    issue(16'h8000,  16'd2,     16'd0,     1'b1, 4);  wait_idle();

    // Start while busy is dropped.
    issue(16'd7, 16'd9, 16'd63, 1'b0, 7);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 16'd2; bus.op_b = 16'd2;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Start during the DONE cycle is dropped.
    issue(16'h0011, 16'd3, 16'h0033, 1'b0, 5);
    wait_done();
    bus.start = 1'b1; bus.op_a = 16'd9; bus.op_b = 16'd9;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Held start launches back-to-back operations.
    bus.start = 1'b1; bus.op_a = 16'd5; bus.op_b = 16'd3;
    push_exp(16'd3, 16'd15, 1'b0, 5);
    push_exp(16'd3, 16'd15, 1'b0, 5);
    @(negedge clk);
    wait_done();
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Reset mid-operation aborts with no done and clears the result.
    bus.start = 1'b1; bus.op_a = 16'd200; bus.op_b = 16'd3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_abort", 64'({bus.busy, bus.done, bus.product, bus.ovf, bus.alu_op, bus.alu_a, bus.alu_b}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(16'd4, 16'd4, 16'd16, 1'b0, 5);
    wait_idle();

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
